// File: rtl/key_input_array_pkg.sv
// Shared types, default timing and counter sizing helpers for the key input front end.
package key_input_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        DELAY  = 2'd2,
        REPEAT = 2'd3
    } rep_state_e;

    localparam int unsigned DEF_N_KEYS          = 4;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_REPEAT_DELAY    = 10;
    localparam int unsigned DEF_REPEAT_PERIOD   = 3;
    localparam logic [3:0]  DEF_REPEAT_MASK     = 4'b0111;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_input_array_if.sv
// Key bus between the push-button pins and the game controller.
interface key_input_array_if #(
    parameter int unsigned N_KEYS = 4
);
    logic [N_KEYS-1:0] in_i;
    logic [N_KEYS-1:0] held_o;
    logic [N_KEYS-1:0] press_o;
    logic [N_KEYS-1:0] fire_o;
    logic [N_KEYS-1:0] release_o;

    modport master (output in_i, input held_o, press_o, fire_o, release_o);
    modport slave  (input in_i, output held_o, press_o, fire_o, release_o);
endinterface

// File: rtl/key_input_array_channel.sv
// One key: synchroniser, debounce filter, edge pulses and typematic repeat FSM.
module key_channel
    import key_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic held_o,
    output logic press_o,
    output logic fire_o,
    output logic release_o
);
    localparam int unsigned CW = cnt_width(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          db_q, db_d;
    logic [CW-1:0]          rc_q, rc_d;
    rep_state_e             state_q, state_d;
    logic                   held_q, held_d;
    logic                   press_q, press_d;
    logic                   fire_q, fire_d;
    logic                   release_q, release_d;
    logic                   s, diff, toggle;

    assign s      = sync_q[SYNC_STAGES-1];
    assign diff   = (s != held_q);
    assign toggle = diff && (db_q == DB_LAST);

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], in_i};
        db_d      = '0;
        held_d    = held_q;
        rc_d      = rc_q;
        state_d   = state_q;
        press_d   = 1'b0;
        fire_d    = 1'b0;
        release_d = 1'b0;

        if (diff && !toggle) begin
            db_d = db_q + 1'b1;
        end

        // Held edges take priority over a repeat falling due in the same cycle.
        if (toggle && !held_q) begin
            held_d  = 1'b1;
            press_d = 1'b1;
            fire_d  = 1'b1;
            rc_d    = '0;
            state_d = REPEAT_EN ? DELAY : HOLD;
        end else if (toggle && held_q) begin
            held_d    = 1'b0;
            release_d = 1'b1;
            rc_d      = '0;
            state_d   = IDLE;
        end else begin
            case (state_q)
                DELAY: begin
                    if (rc_q == RD_LAST) begin
                        fire_d  = 1'b1;
                        rc_d    = '0;
                        state_d = REPEAT;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (rc_q == RP_LAST) begin
                        fire_d = 1'b1;
                        rc_d   = '0;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            db_q      <= '0;
            rc_q      <= '0;
            state_q   <= IDLE;
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            fire_q    <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            db_q      <= db_d;
            rc_q      <= rc_d;
            state_q   <= state_d;
            held_q    <= held_d;
            press_q   <= press_d;
            fire_q    <= fire_d;
            release_q <= release_d;
        end
    end

    assign held_o    = held_q;
    assign press_o   = press_q;
    assign fire_o    = fire_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_input_array.sv
// Multi-key front end: one independent key_channel per board push-button.
module key_input_array
    import key_input_pkg::*;
#(
    parameter int unsigned       N_KEYS          = DEF_N_KEYS,
    parameter int unsigned       SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned       DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned       REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned       REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [N_KEYS-1:0] REPEAT_MASK     = N_KEYS'(DEF_REPEAT_MASK)
) (
    input logic               clk,
    input logic               reset,
    key_input_array_if.slave  keys
);
    logic [N_KEYS-1:0] held_w, press_w, fire_w, release_w;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .in_i      (keys.in_i[i]),
            .held_o    (held_w[i]),
            .press_o   (press_w[i]),
            .fire_o    (fire_w[i]),
            .release_o (release_w[i])
        );
    end

    assign keys.held_o    = held_w;
    assign keys.press_o   = press_w;
    assign keys.fire_o    = fire_w;
    assign keys.release_o = release_w;

endmodule

// File: tb/tb_key_input_array.sv
// Directed checks of key_input_array: reset, debounce, edge pulses and auto-repeat.
module tb_key_input_array;

    logic clk = 1'b0;
    logic reset;
    int unsigned checks;
    int unsigned failures;

    key_input_array_if #(.N_KEYS(4)) kif ();

    key_input_array #(
        .N_KEYS          (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .REPEAT_MASK     (4'b0111)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .keys  (kif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  in;
        int unsigned n;
        logic [3:0]  held;
        logic [3:0]  press;
        logic [3:0]  fire;
        logic [3:0]  rel;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] in, input int unsigned n, input logic [3:0] held,
                       input logic [3:0] press, input logic [3:0] fire, input logic [3:0] rel);
        vec_t v;
        v.in = in; v.n = n; v.held = held; v.press = press; v.fire = fire; v.rel = rel;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] h, input logic [3:0] p,
                       input logic [3:0] f, input logic [3:0] r);
        checks++;
        if ({kif.held_o, kif.press_o, kif.fire_o, kif.release_o} !== {h, p, f, r}) begin
            failures++;
            $display("FAIL %s t=%0t got held=%b press=%b fire=%b release=%b exp held=%b press=%b fire=%b release=%b",
                     name, $time, kif.held_o, kif.press_o, kif.fire_o, kif.release_o, h, p, f, r);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t got no finish exp finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        kif.in_i = 4'b0000;
        #12;
        chk("reset_init", 4'b0, 4'b0, 4'b0, 4'b0);

        // All keys down from reset release; held on the 6th edge.
        reset    = 1'b0;
        kif.in_i = 4'b1111;
        for (int k = 1; k <= 5; k++) begin step(); chk("all_pre", 4'b0, 4'b0, 4'b0, 4'b0); end
        step(); chk("all_press", 4'b1111, 4'b1111, 4'b1111, 4'b0);
        for (int k = 1; k <= 3; k++) begin step(); chk("all_hold", 4'b1111, 4'b0, 4'b0, 4'b0); end

        // Mid-hold asynchronous reset: immediate clear, no release, full re-press latency.
        #2 reset = 1'b1;
        #1 chk("reset_async", 4'b0, 4'b0, 4'b0, 4'b0);
        #2 reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin step(); chk("rearm_pre", 4'b0, 4'b0, 4'b0, 4'b0); end
        step(); chk("rearm_press", 4'b1111, 4'b1111, 4'b1111, 4'b0);
        kif.in_i = 4'b0000;
        for (int k = 1; k <= 5; k++) begin step(); chk("rearm_hold", 4'b1111, 4'b0, 4'b0, 4'b0); end
        step(); chk("rearm_release", 4'b0, 4'b0, 4'b0, 4'b1111);
        for (int k = 1; k <= 3; k++) begin step(); chk("rearm_idle", 4'b0, 4'b0, 4'b0, 4'b0); end

        // Key 3, no repeat: press at edge 6, release 6 edges after drop.
        add(4'b1000, 5,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1000, 1,  4'b1000, 4'b1000, 4'b1000, 4'b0000);
        add(4'b1000, 24, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 5,  4'b1000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 1,  4'b0000, 4'b0000, 4'b0000, 4'b1000);
        add(4'b0000, 4,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Key 0 bounce, longest run 3 cycles.
        add(4'b0001, 1,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 1,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 2,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 1,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 3,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Key 2 released during DELAY: held falls at P+7, no repeat fire.
        add(4'b0100, 5,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0100, 1,  4'b0100, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0100, 1,  4'b0100, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 5,  4'b0100, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 1,  4'b0000, 4'b0000, 4'b0000, 4'b0100);
        add(4'b0000, 6,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Keys 0 and 1 together; the fall at P+19 coincides with a due repeat.
        add(4'b0011, 5,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0011, 1,  4'b0011, 4'b0011, 4'b0011, 4'b0000);
        add(4'b0011, 9,  4'b0011, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0011, 1,  4'b0011, 4'b0000, 4'b0011, 4'b0000);
        add(4'b0011, 2,  4'b0011, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0011, 1,  4'b0011, 4'b0000, 4'b0011, 4'b0000);
        add(4'b0000, 2,  4'b0011, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 1,  4'b0011, 4'b0000, 4'b0011, 4'b0000);
        add(4'b0000, 2,  4'b0011, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 1,  4'b0000, 4'b0000, 4'b0000, 4'b0011);
        add(4'b0000, 3,  4'b0000, 4'b0000, 4'b0000, 4'b0000);

        for (int v = 0; v < tbl.size(); v++) begin
            kif.in_i = tbl[v].in;
            for (int k = 0; k < int'(tbl[v].n); k++) begin
                step();
                chk($sformatf("vec%0d_%0d", v, k), tbl[v].held, tbl[v].press, tbl[v].fire, tbl[v].rel);
            end
        end

        // Key 1 auto-repeat: fires at P, P+10, then every 3 cycles.
        kif.in_i = 4'b0010;
        for (int k = 1; k <= 5; k++) begin step(); chk("rep_pre", 4'b0, 4'b0, 4'b0, 4'b0); end
        step(); chk("rep_press", 4'b0010, 4'b0010, 4'b0010, 4'b0);
        for (int k = 1; k <= 46; k++) begin
            logic due;
            if (k == 41) kif.in_i = 4'b0000;
            step();
            due = (k == 10) || (k > 10 && ((k - 10) % 3) == 0);
            if (k == 40) kif.in_i = 4'b0000;
            if (k < 46)
                chk($sformatf("rep_k%0d", k), 4'b0010, 4'b0, due ? 4'b0010 : 4'b0, 4'b0);
            else
                chk("rep_release_wins", 4'b0, 4'b0, 4'b0, 4'b0010);
        end
        for (int k = 1; k <= 4; k++) begin step(); chk("rep_idle", 4'b0, 4'b0, 4'b0, 4'b0); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_input_array.md
Name: key_input_array

Overview:
- Parametrised multi-key front end for the LED Tetris board. Each key channel has a synchroniser, a debounce filter, press and release edge detection, and optional auto-repeat (typematic) for held keys.
- Replaces the single-key press detector, so held left/right/down keys repeat without game-logic counters.
- Sits between the board push-buttons and the game controller FSM.

Parameters:
N_KEYS, 4, number of independent key channels
SYNC_STAGES, 2, synchroniser flop depth per key (legal >= 2)
DEBOUNCE_CYCLES, 4, consecutive cycles a changed input must persist before it is accepted (legal >= 1)
REPEAT_DELAY, 10, cycles from the press pulse to the first repeat pulse (legal >= 1)
REPEAT_PERIOD, 3, cycles between later repeat pulses (legal >= 1)
REPEAT_MASK, 4'b0111, bit i = 1 enables auto-repeat on key i

Ports:
clk      input   1       system clock
reset    input   1       asynchronous, active-high reset
in       input   N_KEYS  raw asynchronous key levels, 1 = pressed
held     output  N_KEYS  debounced key level
press    output  N_KEYS  one-cycle pulse on each accepted press, initial press only
fire     output  N_KEYS  one-cycle pulse on the initial press and on every auto-repeat
release  output  N_KEYS  one-cycle pulse on each accepted release

Behaviour:
- Reset (async assert, sync release): all synchroniser flops, debounce counters and repeat counters clear to 0. Every FSM goes to IDLE. held, press, fire and release are all 0.
- Channels are fully independent. Every output is registered; nothing is combinational from in.
- Synchroniser: in[i] passes through SYNC_STAGES flops; call the result s[i].
- Debounce:
  - While s[i] != held[i], the counter increments.
  - When s[i] == held[i], the counter clears to 0.
  - If s[i] != held[i] on a cycle where the counter equals DEBOUNCE_CYCLES-1, held[i] toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles (at s) never changes held.
- Latency: held[i] rises on exactly the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising clk edge after the first edge that samples in[i]=1. Release latency is identical.
- press[i] and fire[i] assert in the same cycle that held[i] rises. release[i] asserts in the same cycle that held[i] falls. Each pulse lasts exactly one cycle.
- Per-channel FSM with repeat counter rc:
  - IDLE: on held rise, go to DELAY (repeat enabled) or HOLD (repeat disabled); load rc = 0.
  - HOLD: stays until held falls, then IDLE. No repeats.
  - DELAY: rc increments each cycle. When rc reaches REPEAT_DELAY-1, pulse fire (press stays 0), go to REPEAT, load rc = 0.
  - REPEAT: rc increments each cycle. When rc reaches REPEAT_PERIOD-1, pulse fire and load rc = 0.
  - In any non-IDLE state, a held fall goes to IDLE and clears rc; release pulses. If this coincides with a due repeat, release wins and fire is not asserted.
- Repeat timing: the first repeat fire comes exactly REPEAT_DELAY cycles after the press cycle. Later fires come every REPEAT_PERIOD cycles while held stays 1.
- Reset mid-hold: outputs drop immediately. After reset deasserts with the key still down, the key is treated as a new press after the full latency. No release pulse is produced.
- Counter widths come from a package function and are sized to hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) without wrap-around.

Decomposition:
- Package key_input_pkg:
  - typedef enum for the repeat FSM states {IDLE, HOLD, DELAY, REPEAT}.
  - Function cnt_width(max_val) returning $clog2(max_val+1).
  - Default timing constants.
- Sub-module key_channel: one synchroniser, debounce filter and repeat FSM. It takes the same parameters plus a scalar REPEAT_EN.
- key_input_array generates N_KEYS instances of key_channel.

Test Plan:
- Reset check: assert reset mid-cycle with in = 4'b1111 → all outputs 0 immediately. Deassert reset → held = 4'b1111 on the 6th edge. press and fire pulse 1 cycle on all keys; release stays 0.
- Basic press on key 3 (no repeat): in[3] = 1 held for 30 cycles, then 0.
  - held[3] rises on edge 6; press[3] and fire[3] pulse once; no further fire.
  - release[3] pulses once, 6 edges after in[3] falls.
- Bounce rejection: in[0] toggles with pattern 1,0,1,1,0,1,1,1,0 (runs shorter than 4 cycles at s) → held[0], press[0] and fire[0] stay 0 throughout.
- Auto-repeat on key 1: hold in[1] = 1 for 40 cycles after press.
  - fire[1] pulses at the press cycle P, then at P+10, P+13, P+16, and so on.
  - press[1] pulses only at P.
- Release during DELAY: key 2 pressed, in[2] dropped so held falls at P+7 → release[2] pulses, and no fire at P+10.
- Simultaneous keys: in[0] and in[1] rise on the same edge → identical press timing on both. fire[0] and fire[1] repeat in lockstep; the other channels are unaffected.
